// File: rtl/uniop_pkg.sv
// Shared definitions for the unioperand (accumulator) machine sequencer.
// Holds the default widths, the opcode values, the alu16b sel encoding,
// the FSM state encoding and the decoded instruction classes.
package uniop_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 8;

    // Opcode = instr[15:12]; any value not listed here executes as NOP.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_JMP = 4'h9;
    localparam logic [3:0] OP_JZ  = 4'hA;
    localparam logic [3:0] OP_LDI = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    // alu16b sel encoding
    localparam logic [2:0] SEL_ADD  = 3'd0;
    localparam logic [2:0] SEL_SUB  = 3'd1;
    localparam logic [2:0] SEL_AND  = 3'd2;
    localparam logic [2:0] SEL_OR   = 3'd3;
    localparam logic [2:0] SEL_XOR  = 3'd4;
    localparam logic [2:0] SEL_NOT  = 3'd5;
    localparam logic [2:0] SEL_PASS = 3'd6;

    // FSM state encoding
    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_MEM    = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    // What DECODE does with an instruction.
    typedef enum logic [2:0] {
        CLS_NOP,    // straight back to FETCH
        CLS_JMP,    // unconditional pc load
        CLS_JZ,     // pc load when zflag is set
        CLS_HALT,   // terminal
        CLS_LOAD,   // read M[a] then run the ALU (LDA and the ALU-mem ops)
        CLS_STORE,  // write acc to M[a]
        CLS_EXEC    // ALU only, no memory (LDI, NOT)
    } op_class_t;

endpackage

// File: rtl/uniop_decode.sv
// Combinational opcode decoder.
// Ports:
//   opcode   in   4   instr[15:12]
//   op_class out      what the sequencer does next with this instruction
//   alu_sel  out  3   alu16b sel for instructions that go through the ALU
module uniop_decode
    import uniop_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_t  op_class,
    output logic [2:0] alu_sel
);

    always_comb begin
        op_class = CLS_NOP;
        alu_sel  = SEL_PASS;
        case (opcode)
            OP_LDA: begin op_class = CLS_LOAD;  alu_sel = SEL_PASS; end
            OP_STA: begin op_class = CLS_STORE; end
            OP_ADD: begin op_class = CLS_LOAD;  alu_sel = SEL_ADD;  end
            OP_SUB: begin op_class = CLS_LOAD;  alu_sel = SEL_SUB;  end
            OP_AND: begin op_class = CLS_LOAD;  alu_sel = SEL_AND;  end
            OP_OR:  begin op_class = CLS_LOAD;  alu_sel = SEL_OR;   end
            OP_XOR: begin op_class = CLS_LOAD;  alu_sel = SEL_XOR;  end
            OP_NOT: begin op_class = CLS_EXEC;  alu_sel = SEL_NOT;  end
            OP_JMP: begin op_class = CLS_JMP;   end
            OP_JZ:  begin op_class = CLS_JZ;    end
            OP_LDI: begin op_class = CLS_EXEC;  alu_sel = SEL_PASS; end
            OP_HLT: begin op_class = CLS_HALT;  end
            default: begin op_class = CLS_NOP;  end
        endcase
    end

endmodule

// File: rtl/uniop_ctrl.sv
// Multicycle sequencer for the accumulator machine, driving alu16b.
// Fetches instructions, performs data loads/stores, sequences the ALU and
// writes its registered result back into the accumulator and zero flag.
// Ports:
//   clk, rst                          clock, asynchronous active-high reset
//   imem_req/addr/rdata/valid         instruction fetch handshake (addr = pc)
//   dmem_req/we/addr/wdata/rdata/valid data memory handshake
//   alu_in1/in2/sel                   operands and function to alu16b
//   alu_out/alu_zf                    alu16b result, one cycle after EXEC
//   acc, pc, halted                   architectural state
module uniop_ctrl
    import uniop_pkg::*;
#(
    parameter int                DATA_W   = DATA_W_DEF,
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] START_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_valid,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_valid,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [2:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zf,
    output logic [DATA_W-1:0] acc,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);

    logic [2:0]        state_reg,      state_next;
    logic [ADDR_W-1:0] pc_reg,         pc_next;
    logic [15:0]       ir_reg,         ir_next;
    logic [DATA_W-1:0] acc_reg,        acc_next;
    logic              zflag_reg,      zflag_next;
    logic              imem_req_reg,   imem_req_next;
    logic              dmem_req_reg,   dmem_req_next;
    logic              dmem_we_reg,    dmem_we_next;
    logic [ADDR_W-1:0] dmem_addr_reg,  dmem_addr_next;
    logic [DATA_W-1:0] dmem_wdata_reg, dmem_wdata_next;
    logic [DATA_W-1:0] alu_in1_reg,    alu_in1_next;
    logic [DATA_W-1:0] alu_in2_reg,    alu_in2_next;
    logic [2:0]        alu_sel_reg,    alu_sel_next;

    op_class_t         dec_class;
    logic [2:0]        dec_sel;
    logic [ADDR_W-1:0] operand_addr;
    logic [DATA_W-1:0] imm;
    logic              imem_fire;
    logic              dmem_fire;

    uniop_decode u_decode (
        .opcode   (ir_reg[15:12]),
        .op_class (dec_class),
        .alu_sel  (dec_sel)
    );

    assign operand_addr = ir_reg[ADDR_W-1:0];

    // Zero-extended immediate for LDI.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_imm
            if (gi < ADDR_W) begin : g_bit
                assign imm[gi] = ir_reg[gi];
            end else begin : g_zero
                assign imm[gi] = 1'b0;
            end
        end
        if (ADDR_W < 12) begin : g_ir_gap
            // Instruction bits between the opcode and the operand carry no meaning.
            logic unused_ir;
            assign unused_ir = ^ir_reg[11:ADDR_W];
        end
    endgenerate

    // A valid only completes a transaction that is actually being requested.
    assign imem_fire = imem_req_reg & imem_valid;
    assign dmem_fire = dmem_req_reg & dmem_valid;

    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        ir_next         = ir_reg;
        acc_next        = acc_reg;
        zflag_next      = zflag_reg;
        dmem_we_next    = dmem_we_reg;
        dmem_addr_next  = dmem_addr_reg;
        dmem_wdata_next = dmem_wdata_reg;
        alu_in1_next    = alu_in1_reg;
        alu_in2_next    = alu_in2_reg;
        alu_sel_next    = alu_sel_reg;
        case (state_reg)
            ST_FETCH: begin
                if (imem_fire) begin
                    ir_next    = imem_rdata;
                    pc_next    = pc_reg + 1'b1;
                    state_next = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (dec_class)
                    CLS_JMP: begin
                        pc_next    = operand_addr;
                        state_next = ST_FETCH;
                    end
                    CLS_JZ: begin
                        if (zflag_reg) begin
                            pc_next = operand_addr;
                        end
                        state_next = ST_FETCH;
                    end
                    CLS_HALT: state_next = ST_HALT;
                    CLS_LOAD: begin
                        dmem_we_next   = 1'b0;
                        dmem_addr_next = operand_addr;
                        state_next     = ST_MEM;
                    end
                    CLS_STORE: begin
                        dmem_we_next    = 1'b1;
                        dmem_addr_next  = operand_addr;
                        dmem_wdata_next = acc_reg;
                        state_next      = ST_MEM;
                    end
                    CLS_EXEC: begin
                        // ALU operands are registered on entry to EXEC so the
                        // registered alu16b result is ready during WB.
                        alu_in1_next = acc_reg;
                        alu_in2_next = imm;
                        alu_sel_next = dec_sel;
                        state_next   = ST_EXEC;
                    end
                    default: state_next = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                if (dmem_fire) begin
                    if (dmem_we_reg) begin
                        state_next = ST_FETCH;
                    end else begin
                        alu_in1_next = acc_reg;
                        alu_in2_next = dmem_rdata;
                        alu_sel_next = dec_sel;
                        state_next   = ST_EXEC;
                    end
                end
            end
            ST_EXEC: state_next = ST_WB;
            ST_WB: begin
                acc_next   = alu_out;
                zflag_next = alu_zf;
                state_next = ST_FETCH;
            end
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_FETCH;
        endcase
        // Requests are registered from the upcoming state so they are high
        // for the whole of FETCH/MEM and drop the cycle after completion.
        imem_req_next = (state_next == ST_FETCH);
        dmem_req_next = (state_next == ST_MEM);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_FETCH;
            pc_reg         <= START_PC;
            ir_reg         <= '0;
            acc_reg        <= '0;
            zflag_reg      <= 1'b0;
            imem_req_reg   <= 1'b0;
            dmem_req_reg   <= 1'b0;
            dmem_we_reg    <= 1'b0;
            dmem_addr_reg  <= '0;
            dmem_wdata_reg <= '0;
            alu_in1_reg    <= '0;
            alu_in2_reg    <= '0;
            alu_sel_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            ir_reg         <= ir_next;
            acc_reg        <= acc_next;
            zflag_reg      <= zflag_next;
            imem_req_reg   <= imem_req_next;
            dmem_req_reg   <= dmem_req_next;
            dmem_we_reg    <= dmem_we_next;
            dmem_addr_reg  <= dmem_addr_next;
            dmem_wdata_reg <= dmem_wdata_next;
            alu_in1_reg    <= alu_in1_next;
            alu_in2_reg    <= alu_in2_next;
            alu_sel_reg    <= alu_sel_next;
        end
    end

    assign imem_req   = imem_req_reg;
    assign imem_addr  = pc_reg;
    assign dmem_req   = dmem_req_reg;
    assign dmem_we    = dmem_we_reg;
    assign dmem_addr  = dmem_addr_reg;
    assign dmem_wdata = dmem_wdata_reg;
    assign alu_in1    = alu_in1_reg;
    assign alu_in2    = alu_in2_reg;
    assign alu_sel    = alu_sel_reg;
    assign acc        = acc_reg;
    assign pc         = pc_reg;
    assign halted     = (state_reg == ST_HALT);

endmodule

// File: tb/tb_uniop_ctrl.sv
module tb_uniop_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        dmem_req;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [15:0] dmem_wdata;
    logic [15:0] dmem_rdata;
    logic        dmem_valid;
    logic [15:0] alu_in1;
    logic [15:0] alu_in2;
    logic [2:0]  alu_sel;
    logic [15:0] alu_out = '0;
    logic        alu_zf = 1'b0;
    logic [15:0] acc;
    logic [7:0]  pc;
    logic        halted;

    uniop_ctrl #(.DATA_W(16), .ADDR_W(8), .START_PC(8'h00)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_valid(dmem_valid),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_sel(alu_sel), .alu_out(alu_out), .alu_zf(alu_zf),
        .acc(acc), .pc(pc), .halted(halted)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // alu16b reference: registered, one-cycle latency.
    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [2:0] s);
        case (s)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~a;
            3'd6: return b;
            default: return 16'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        alu_out <= alu_f(alu_in1, alu_in2, alu_sel);
        alu_zf  <= (alu_f(alu_in1, alu_in2, alu_sel) == 16'h0);
        cyc     <= cyc + 1;
    end

    // Memory models: instruction side with programmable wait states and a
    // stray-valid injector, data side zero-wait.
    logic [15:0] imem [256];
    logic [15:0] dmem [256];
    int          imem_delay = 0;
    int          wait_cnt = 0;
    logic        stray = 1'b0;

    assign imem_rdata = imem[imem_addr];
    assign imem_valid = (imem_req && (wait_cnt >= imem_delay)) || stray;
    assign dmem_rdata = dmem[dmem_addr];
    assign dmem_valid = dmem_req;

    always @(posedge clk) begin
        wait_cnt <= (imem_req && !imem_valid) ? wait_cnt + 1 : 0;
        if (dmem_req && dmem_valid && dmem_we) dmem[dmem_addr] <= dmem_wdata;
    end

    // Scoreboards: expected fetch addresses and expected stores {addr,data}.
    logic [7:0]  exp_fetch [$];
    logic [23:0] exp_wr [$];
    int          fetch_cyc [$];

    always @(negedge clk) begin
        if (imem_req && imem_valid) begin
            logic ok;
            fetch_cyc.push_back(cyc);
            ok = (exp_fetch.size() > 0);
            check("fetch_pending", 32'(ok), 32'd1);
            if (ok) begin
                logic [7:0] ea;
                ea = exp_fetch.pop_front();
                check("fetch_addr", 32'(imem_addr), 32'(ea));
                $display("fetch   cyc=%0d addr=%02h instr=%04h", cyc, imem_addr, imem_rdata);
            end
        end
        if (dmem_req && dmem_valid && dmem_we) begin
            logic ok;
            ok = (exp_wr.size() > 0);
            check("store_pending", 32'(ok), 32'd1);
            if (ok) begin
                logic [23:0] ew;
                ew = exp_wr.pop_front();
                check("store_addr", 32'(dmem_addr), 32'(ew[23:16]));
                check("store_data", 32'(dmem_wdata), 32'(ew[15:0]));
                $display("store   cyc=%0d addr=%02h data=%04h", cyc, dmem_addr, dmem_wdata);
            end
        end
    end

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) begin
            imem[i] = 16'hF000;
            dmem[i] = 16'h0000;
        end
        exp_fetch.delete();
        exp_wr.delete();
        fetch_cyc.delete();
    endtask

    task automatic enter_reset();
        rst = 1'b1;
        @(negedge clk);
        clear_mem();
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_halted(input string tag, input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(halted), 32'd1);
    endtask

    task automatic end_run(input string tag);
        check({tag, "_fetch_q_empty"}, 32'(exp_fetch.size()), 32'd0);
        check({tag, "_store_q_empty"}, 32'(exp_wr.size()), 32'd0);
        $display("run     %s acc=%04h pc=%02h halted=%0b", tag, acc, pc, halted);
    endtask

    initial begin
        // Reset state
        clear_mem();
        @(negedge clk);
        @(negedge clk);
        check("rst_imem_req", 32'(imem_req), 0);
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_dmem_req", 32'(dmem_req), 0);
        check("rst_dmem_we", 32'(dmem_we), 0);
        check("rst_dmem_addr", 32'(dmem_addr), 0);
        check("rst_dmem_wdata", 32'(dmem_wdata), 0);
        check("rst_alu_in1", 32'(alu_in1), 0);
        check("rst_alu_in2", 32'(alu_in2), 0);
        check("rst_alu_sel", 32'(alu_sel), 0);
        check("rst_acc", 32'(acc), 0);
        check("rst_pc", 32'(pc), 0);
        check("rst_halted", 32'(halted), 0);

        // Run 1: LDI 5; ADD [0x10]; STA 0x11; HLT
        enter_reset();
        imem[0] = 16'hB005; imem[1] = 16'h3010; imem[2] = 16'h2011; imem[3] = 16'hF000;
        dmem[8'h10] = 16'd3;
        exp_fetch = '{8'h00, 8'h01, 8'h02, 8'h03};
        exp_wr.push_back({8'h11, 16'd8});
        release_reset();
        wait_halted("r1_halted", 100);
        check("r1_acc", 32'(acc), 32'd8);
        check("r1_pc", 32'(pc), 32'd4);
        check("r1_mem11", 32'(dmem[8'h11]), 32'd8);
        check("r1_imem_req_idle", 32'(imem_req), 0);
        check("r1_dmem_req_idle", 32'(dmem_req), 0);
        if (fetch_cyc.size() == 4) begin
            check("r1_cost_ldi", 32'(fetch_cyc[1] - fetch_cyc[0]), 32'd4);
            check("r1_cost_add", 32'(fetch_cyc[2] - fetch_cyc[1]), 32'd5);
            check("r1_cost_sta", 32'(fetch_cyc[3] - fetch_cyc[2]), 32'd3);
        end else begin
            check("r1_fetch_count", 32'(fetch_cyc.size()), 32'd4);
        end
        end_run("r1");

        // Run 2: LDI 7; SUB [0x10]=7; JZ 0x08 taken; HLT at 0x08
        enter_reset();
        imem[0] = 16'hB007; imem[1] = 16'h4010; imem[2] = 16'hA008; imem[8] = 16'hF000;
        dmem[8'h10] = 16'd7;
        exp_fetch = '{8'h00, 8'h01, 8'h02, 8'h08};
        release_reset();
        wait_halted("r2_halted", 100);
        check("r2_acc", 32'(acc), 32'd0);
        check("r2_pc", 32'(pc), 32'h09);
        end_run("r2");

        // Run 3: LDI 1; JZ 0x20 not taken; next fetch at 2
        enter_reset();
        imem[0] = 16'hB001; imem[1] = 16'hA020; imem[2] = 16'hF000;
        exp_fetch = '{8'h00, 8'h01, 8'h02};
        release_reset();
        wait_halted("r3_halted", 100);
        check("r3_acc", 32'(acc), 32'd1);
        check("r3_pc", 32'(pc), 32'd3);
        if (fetch_cyc.size() == 3) check("r3_cost_jz", 32'(fetch_cyc[2] - fetch_cyc[1]), 32'd2);
        else check("r3_fetch_count", 32'(fetch_cyc.size()), 32'd3);
        end_run("r3");

        // Run 4: pc wrap: JZ 3 (not taken); LDI 0; JMP FF; NOP at FF -> 0; JZ 3 taken; HLT
        enter_reset();
        imem[0] = 16'hA003; imem[1] = 16'hB000; imem[2] = 16'h90FF; imem[8'hFF] = 16'h0000;
        imem[3] = 16'hF000;
        exp_fetch = '{8'h00, 8'h01, 8'h02, 8'hFF, 8'h00, 8'h03};
        release_reset();
        wait_halted("r4_halted", 100);
        check("r4_pc", 32'(pc), 32'd4);
        if (fetch_cyc.size() == 6) check("r4_cost_nop", 32'(fetch_cyc[4] - fetch_cyc[3]), 32'd2);
        else check("r4_fetch_count", 32'(fetch_cyc.size()), 32'd6);
        end_run("r4");

        // Run 5: LDI 0; NOT -> FFFF; STA 0x20; NOT -> 0 (zflag); JZ 0x10 taken
        enter_reset();
        imem[0] = 16'hB000; imem[1] = 16'h8000; imem[2] = 16'h2020; imem[3] = 16'h8000;
        imem[4] = 16'hA010; imem[8'h10] = 16'hF000;
        exp_fetch = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10};
        exp_wr.push_back({8'h20, 16'hFFFF});
        release_reset();
        wait_halted("r5_halted", 100);
        check("r5_acc", 32'(acc), 32'd0);
        check("r5_pc", 32'(pc), 32'h11);
        end_run("r5");

        // Run 6: 3-cycle imem wait states; request and address must hold
        enter_reset();
        imem[0] = 16'hB042; imem[1] = 16'hF000;
        exp_fetch = '{8'h00, 8'h01};
        imem_delay = 3;
        release_reset();
        begin
            int n = 0;
            while (!imem_req && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("r6_req_seen", 32'(imem_req), 1);
            for (int i = 0; i < 3; i++) begin
                check("r6_hold_req", 32'(imem_req), 1);
                check("r6_hold_addr", 32'(imem_addr), 0);
                check("r6_hold_novalid", 32'(imem_valid), 0);
                @(negedge clk);
            end
            check("r6_valid_after_wait", 32'(imem_valid && imem_req), 1);
        end
        wait_halted("r6_halted", 100);
        check("r6_acc", 32'(acc), 32'h42);
        imem_delay = 0;
        end_run("r6");

        // Run 7: stray imem_valid pulse during DECODE is ignored
        enter_reset();
        imem[0] = 16'h0000; imem[1] = 16'hB003; imem[2] = 16'hF000;
        exp_fetch = '{8'h00, 8'h01, 8'h02};
        release_reset();
        begin
            int n = 0;
            while (!(imem_req && imem_valid) && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("r7_first_fetch", 32'(imem_req && imem_valid), 1);
            @(posedge clk);
            #1 stray = 1'b1;
            check("r7_decode_noreq", 32'(imem_req), 0);
            @(posedge clk);
            #1 stray = 1'b0;
            check("r7_pc_after_stray", 32'(pc), 32'd1);
        end
        wait_halted("r7_halted", 100);
        check("r7_acc", 32'(acc), 32'd3);
        check("r7_pc", 32'(pc), 32'd3);
        end_run("r7");

        // Run 8: reset during MEM drops dmem_req at once; restart at START_PC
        enter_reset();
        imem[0] = 16'h1010; imem[1] = 16'hF000;
        dmem[8'h10] = 16'h1234;
        exp_fetch = '{8'h00, 8'h00, 8'h01};
        release_reset();
        begin
            int n = 0;
            while (!dmem_req && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("r8_dmem_req_seen", 32'(dmem_req), 1);
            rst = 1'b1;
            #1;
            check("r8_rst_dmem_req", 32'(dmem_req), 0);
            check("r8_rst_imem_req", 32'(imem_req), 0);
            check("r8_rst_pc", 32'(pc), 0);
            @(negedge clk);
            rst = 1'b0;
        end
        wait_halted("r8_halted", 100);
        check("r8_acc", 32'(acc), 32'h1234);
        check("r8_pc", 32'(pc), 32'd2);
        end_run("r8");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
